// File: rtl/sht_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sht_frame_decoder
// Brief    : Splits an SHT40 6-byte read into T/RH words, checks each with the
//            Sensirion CRC-8 and publishes verified raw words with error flags.
// Revision : 1.0 - initial release
// ============================================================================
module sht_frame_decoder #(
  parameter logic [7:0] CRC_POLY  = 8'h31,
  parameter logic [7:0] CRC_INIT  = 8'hFF,
  parameter bit         CHECK_CRC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Frame_Start,
  input  logic        Byte_Valid,
  input  logic [7:0]  Byte_Data,
  output logic        Byte_Ready,
  output logic [2:0]  Byte_Index,
  output logic [15:0] Temperature_Output,
  output logic [15:0] Humidity_Output,
  output logic        Temp_CRC_Error,
  output logic        RH_CRC_Error,
  output logic        Frame_Valid,
  output logic        Overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam logic [2:0] c_IDX_T_CRC  = 3'd2;
  localparam logic [2:0] c_IDX_RH_CRC = 3'd5;

  state_t      r_state,      w_state_nxt;
  logic [2:0]  r_index,      w_index_nxt;
  logic [7:0]  r_crc,        w_crc_nxt;
  logic [2:0]  r_bit_cnt,    w_bit_cnt_nxt;
  logic [7:0]  r_word_hi,    w_word_hi_nxt;
  logic [7:0]  r_word_lo,    w_word_lo_nxt;
  logic [15:0] r_temp,       w_temp_nxt;
  logic [15:0] r_hum,        w_hum_nxt;
  logic        r_temp_err,   w_temp_err_nxt;
  logic        r_rh_err,     w_rh_err_nxt;
  logic        r_frame_vld,  w_frame_vld_nxt;
  logic        r_overrun,    w_overrun_nxt;
  logic        r_frame_drop, w_frame_drop_nxt;

  logic        w_ready;
  logic        w_accept;
  logic [2:0]  w_idx;
  logic        w_data_idx;
  logic [7:0]  w_crc_seed;
  logic [7:0]  w_crc_step;
  logic        w_match;

  always_comb begin
    w_ready    = (r_state == S_IDLE);
    // Frame_Start resynchronises first, so a coincident byte lands as index 0
    w_idx      = Frame_Start ? 3'd0 : r_index;
    w_accept   = Byte_Valid && (Frame_Start || w_ready);
    w_data_idx = (w_idx != c_IDX_T_CRC) && (w_idx != c_IDX_RH_CRC);
    w_crc_seed = ((w_idx == 3'd0) || (w_idx == 3'd3)) ? CRC_INIT : r_crc;
    w_crc_step = r_crc[7] ? ({r_crc[6:0], 1'b0} ^ CRC_POLY) : {r_crc[6:0], 1'b0};
    w_match    = (r_crc == Byte_Data) || (CHECK_CRC == 1'b0);

    w_state_nxt      = r_state;
    w_index_nxt      = r_index;
    w_crc_nxt        = r_crc;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_word_hi_nxt    = r_word_hi;
    w_word_lo_nxt    = r_word_lo;
    w_temp_nxt       = r_temp;
    w_hum_nxt        = r_hum;
    w_temp_err_nxt   = r_temp_err;
    w_rh_err_nxt     = r_rh_err;
    w_frame_vld_nxt  = 1'b0;
    w_overrun_nxt    = r_overrun;
    w_frame_drop_nxt = r_frame_drop;

    if (Frame_Start) begin
      w_state_nxt      = S_IDLE;
      w_index_nxt      = 3'd0;
      w_crc_nxt        = CRC_INIT;
      w_bit_cnt_nxt    = 3'd0;
      w_overrun_nxt    = 1'b0;
      w_frame_drop_nxt = 1'b0;
    end else begin
      if (Byte_Valid && !w_ready) begin
        w_overrun_nxt    = 1'b1;
        w_frame_drop_nxt = 1'b1;
      end
      case (r_state)
        S_SHIFT: begin
          w_crc_nxt     = w_crc_step;
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_index_nxt = r_index + 3'd1;
            w_state_nxt = S_IDLE;
          end
        end
        S_CHECK: begin
          w_index_nxt = (r_index == c_IDX_RH_CRC) ? 3'd0 : r_index + 3'd1;
          w_state_nxt = S_IDLE;
        end
        default: ;
      endcase
    end

    if (w_accept) begin
      if (w_data_idx) begin
        if ((w_idx == 3'd0) || (w_idx == 3'd3)) begin
          w_word_hi_nxt = Byte_Data;
        end else begin
          w_word_lo_nxt = Byte_Data;
        end
        w_crc_nxt     = w_crc_seed ^ Byte_Data;
        w_bit_cnt_nxt = 3'd0;
        w_state_nxt   = S_SHIFT;
      end else begin
        w_state_nxt = S_CHECK;
        if (w_idx == c_IDX_T_CRC) begin
          w_temp_err_nxt = !w_match;
          if (w_match) w_temp_nxt = {r_word_hi, r_word_lo};
        end else begin
          w_rh_err_nxt = !w_match;
          if (w_match) w_hum_nxt = {r_word_hi, r_word_lo};
          // a frame that lost any byte never reports completion
          w_frame_vld_nxt  = !r_frame_drop;
          w_frame_drop_nxt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_index      <= 3'd0;
      r_crc        <= 8'd0;
      r_bit_cnt    <= 3'd0;
      r_word_hi    <= 8'd0;
      r_word_lo    <= 8'd0;
      r_temp       <= 16'd0;
      r_hum        <= 16'd0;
      r_temp_err   <= 1'b0;
      r_rh_err     <= 1'b0;
      r_frame_vld  <= 1'b0;
      r_overrun    <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_index      <= w_index_nxt;
      r_crc        <= w_crc_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_word_hi    <= w_word_hi_nxt;
      r_word_lo    <= w_word_lo_nxt;
      r_temp       <= w_temp_nxt;
      r_hum        <= w_hum_nxt;
      r_temp_err   <= w_temp_err_nxt;
      r_rh_err     <= w_rh_err_nxt;
      r_frame_vld  <= w_frame_vld_nxt;
      r_overrun    <= w_overrun_nxt;
      r_frame_drop <= w_frame_drop_nxt;
    end
  end

  assign Byte_Ready         = w_ready;
  assign Byte_Index         = r_index;
  assign Temperature_Output = r_temp;
  assign Humidity_Output    = r_hum;
  assign Temp_CRC_Error     = r_temp_err;
  assign RH_CRC_Error       = r_rh_err;
  assign Frame_Valid        = r_frame_vld;
  assign Overrun            = r_overrun;

endmodule
`default_nettype wire

// File: doc/sht_frame_decoder.md
Name: sht_frame_decoder

Overview:
- Consumes the byte stream the I2C master delivers from an SHT40 measurement read.
- A read is 6 bytes: T_msb, T_lsb, T_crc, RH_msb, RH_lsb, RH_crc.
- Runs the Sensirion CRC-8 over each 2-byte word, compares it against the received CRC byte, and publishes verified 16-bit raw temperature and humidity words with per-word error flags.
- Sits between the master's received-byte output and the downstream conversion/processor logic.

Parameters:
- CRC_POLY, 8'h31, CRC-8 polynomial (x^8+x^5+x^4+1).
- CRC_INIT, 8'hFF, CRC register value at the start of each word.
- CHECK_CRC, 1, 1 = compare CRC bytes; 0 = treat every CRC byte as a match.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- Frame_Start  input  1  one-cycle pulse at start of a measurement read; resynchronises the byte index
- Byte_Valid  input  1  one-cycle strobe: Byte_Data holds a received byte
- Byte_Data  input  8  received byte, MSB first as on the bus
- Byte_Ready  output  1  high when a byte can be accepted (CRC engine idle)
- Byte_Index  output  3  index (0..5) the next accepted byte will take
- Temperature_Output  output  16  last CRC-verified raw temperature word
- Humidity_Output  output  16  last CRC-verified raw humidity word
- Temp_CRC_Error  output  1  result of the last temperature CRC compare
- RH_CRC_Error  output  1  result of the last humidity CRC compare
- Frame_Valid  output  1  one-cycle pulse after byte 5 is processed
- Overrun  output  1  sticky: a byte arrived while Byte_Ready was low

Behaviour:
- Reset: all outputs 0 except Byte_Ready=1. Index, CRC register and word holding register cleared. Reset mid-frame discards all partial state.
- States: IDLE, SHIFT, CHECK.
- IDLE, Byte_Valid with index 0/1/3/4 (data byte):
  - store the byte into word_hi (index 0/3) or word_lo (index 1/4);
  - XOR the byte into the CRC register (register = CRC_INIT for index 0/3);
  - go to SHIFT, Byte_Ready low.
- SHIFT: 8 cycles, one bit per cycle. If crc[7]: crc = (crc<<1)^CRC_POLY, else crc = crc<<1, 8-bit truncated. After the 8th cycle: index+1, back to IDLE, Byte_Ready high. A data byte therefore blocks for exactly 8 cycles after its strobe cycle.
- IDLE, Byte_Valid with index 2/5 (CRC byte): go to CHECK for 1 cycle, Byte_Ready low.
  - Match = (crc == Byte_Data) || !CHECK_CRC.
  - Index 2: Temp_CRC_Error <= !match; Temperature_Output <= {word_hi, word_lo} only if match.
  - Index 5: RH_CRC_Error <= !match; Humidity_Output likewise; Frame_Valid pulses on the same edge.
  - Index 5 wraps to 0, so back-to-back frames work without Frame_Start.
- Error flags hold their value until the next compare of the same word or reset. Outputs keep their old value on mismatch.
- Byte_Valid while Byte_Ready low: byte dropped, index unchanged, Overrun <= 1. Overrun clears only on Frame_Start or rst.
- Frame_Start:
  - index <= 0, CRC <= CRC_INIT, Overrun <= 0;
  - any SHIFT/CHECK in progress is aborted, Byte_Ready <= 1;
  - a Frame_Valid that would occur on that edge is suppressed.
  - Frame_Start and Byte_Valid in the same cycle: Frame_Start applied first, and the byte is accepted as index 0.
- Frame_Valid never asserts for a frame in which any byte was dropped; overrun remains flagged.
- Published outputs change only on CRC-byte edges.

Test Plan:
- Good frame: rst, Frame_Start, bytes BE EF 92 AB CD 6F, each sent when Byte_Ready=1 -> Temperature_Output=16'hBEEF, Humidity_Output=16'hABCD, both errors 0, one-cycle Frame_Valid one edge after the 6F strobe, Byte_Index=0.
- Bad RH CRC: same bytes with last = 6E -> Humidity_Output keeps its previous value (0 after reset), RH_CRC_Error=1, Temp_CRC_Error=0, Temperature_Output=BEEF, Frame_Valid pulses.
- Overrun: strobe BE, then EF 3 cycles later -> EF dropped, Overrun=1, Byte_Index=1 after SHIFT completes. Next Frame_Start -> Overrun=0, Byte_Index=0.
- Back-to-back: two good frames without a second Frame_Start, second frame 12 34 37 56 78 7D -> second frame publishes 1234/5678, no errors, two Frame_Valid pulses.
- Resync: Frame_Start mid-SHIFT of byte 1, followed by a full good frame -> Byte_Ready high on the next edge, outputs BEEF/ABCD, no Frame_Valid from the aborted frame.
- CHECK_CRC=0: bytes BE EF 00 AB CD 00 -> outputs BEEF/ABCD, both errors 0. Also assert rst mid-frame -> all outputs 0 the next cycle.
